event_queue_axil: RTL and testbench
===================================

# event_queue_axil

Parametrised event FIFO with an AXI4-Lite register window; the next generation of the event capture path between the event decoder and the CPU. The decoder pushes DATA_W-bit event codes with a one-cycle strobe; software drains them through a pop-on-read DATA register. Adds:

- inferred storage of configurable depth;
- fill-level and threshold registers;
- a sticky overflow flag;
- a software flush;
- a level-sensitive interrupt.

## Interface
- DATA_W, 8: event code width, 1..31.
- DEPTH, 512: FIFO entries, power of two, 16..4096.
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  reset, synchronous, active-low.
- wr_en  in  1  push strobe, one event per cycle high.
- data_in  in  DATA_W  event code, sampled when wr_en=1.
- irq  out  1  interrupt request, registered, level.
- axi  axi4_lite_if.s  MMR_DEV_ADDR_W addr / MMR_DATA_W (32) data  register slave.

## Operation
- Register map (byte offsets). Undecoded reads return 0; undecoded writes are ignored.
  - SR 0x00: bit0 empty, bit1 full, bit2 overflow (sticky), bit3 thr (level >= THRESH, THRESH != 0). Writing 1 to bit2 clears overflow; other bits are RO.
  - CR 0x04: bit0 flush (self-clearing, reads 0), bit1 irq_en.
  - CR_S 0x08: CR |= wdata. Write-only; reads return 0.
  - CR_C 0x0C: CR &= ~wdata. Write-only; reads return 0.
  - LEVEL 0x10: RO, entries held, 0..DEPTH.
  - DATA 0x14: RO, {valid at bit31, zeros, event at [DATA_W-1:0]}.
    - Read with level > 0 pops one entry and returns valid=1.
    - Read when empty returns 0 and does not pop.
  - THRESH 0x18: RW, low $clog2(DEPTH)+1 bits. Upper bits read 0.
- FIFO storage and pointers:
  - Storage is a DEPTH x DATA_W array suitable for block-RAM inference.
  - Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - level is a separate counter.
- Push: wr_en=1 and level < DEPTH at the start of the cycle.
  - When full, the push is dropped and overflow is set, even if a pop occurs in the same cycle.
- Simultaneous push and pop: level is unchanged and both pointers advance.
- Flush (a CR, CR_S or CR_C write with bit0=1):
  - Zeroes both pointers and level at the B-handshake cycle.
  - A push in that cycle is dropped.
  - Overflow is not touched.
- irq is registered: irq <= irq_en & (thr | overflow).
- AXI read FSM, states R_IDLE -> R_LAT -> R_RESP -> R_IDLE:
  - R_IDLE: arready=1. On arvalid, latch araddr and go to R_LAT. A DATA pop decision is taken here.
  - R_LAT: arready=0. Memory read is in flight.
  - R_RESP: rvalid=1 and rdata is stable until rready. Go to R_IDLE on rready.
- AXI write path:
  - AW and W are accepted independently (one-cycle awready/wready pulses) and held until both are present.
  - Then bvalid=1 until bready. The register update occurs in the B-handshake cycle.
  - A new AW/W is not accepted until the B handshake completes.
- rresp and bresp are always OKAY (2'b00).
- A single register file is shared. Read and write address latches are separate, so concurrent read and write transactions do not corrupt each other.

## Timing
- Reset values:
  - AXI: arready 0, rvalid 0, rdata 0, awready 0, wready 0, bvalid 0, resp 0.
  - Control: irq 0, CR 0, THRESH 0, overflow 0, level 0, pointers 0.
  - FSM in R_IDLE. arready rises the cycle after aresetn deasserts.
- Read latency: AR handshake at cycle T, rvalid at T+2. Minimum issue rate is one read per 3 cycles when rready is held high.
- A DATA pop updates level at T+1, so LEVEL read afterwards reflects it.
- Push latency: wr_en at cycle T gives level, SR and the entry at T+1, and irq at T+2.
- Write: both AW and W seen at T gives bvalid at T+1; effect is visible in the cycle after the B handshake.
- Reset asserted mid-transaction aborts it. No response is issued and FIFO contents are discarded.

## Test plan
- After reset, read SR and LEVEL -> SR=0x1, LEVEL=0. DATA read -> 0x00000000, LEVEL stays 0.
- Push 0x11, 0x22, 0x33 -> LEVEL=3. Three DATA reads -> 0x80000011, 0x80000022, 0x80000033, then SR.empty=1.
- Push DEPTH+2 events (DEPTH=16) -> LEVEL=16, SR=0x6, first 16 codes read back in order. Write SR=0x4 -> overflow clears.
- THRESH=4, CR_S=0x2 -> irq rises 2 cycles after the 4th push. A DATA pop to level 3 -> irq falls 2 cycles later.
- Fill 5 events, CR_S=0x1 with a push in the B-handshake cycle -> LEVEL=0, SR.empty=1, CR reads 0x2 if irq_en was set.
- Push every cycle while DATA reads run back-to-back at a full FIFO -> no data loss beyond flagged overflow. Order preserved across pointer wrap (DEPTH=16, 40 events).

Source files
------------

// File: rtl/event_queue_axil_if.sv
// AXI4-Lite bus bundle used for the event queue register window.
interface axi4_lite_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) ();
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport s (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport m (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/event_queue_axil.sv
// Event FIFO fed by a push strobe and drained by software through a pop-on-read
// AXI4-Lite register window, with level/threshold status, sticky overflow and irq.
module event_queue_axil #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned DEPTH          = 512,
  parameter int unsigned MMR_DEV_ADDR_W = 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_data_in,
  output logic              o_irq,
  axi4_lite_if.s            axi
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned AW    = MMR_DEV_ADDR_W;

  localparam logic [AW-1:0] ADDR_SR     = AW'(32'h00);
  localparam logic [AW-1:0] ADDR_CR     = AW'(32'h04);
  localparam logic [AW-1:0] ADDR_CR_S   = AW'(32'h08);
  localparam logic [AW-1:0] ADDR_CR_C   = AW'(32'h0C);
  localparam logic [AW-1:0] ADDR_LEVEL  = AW'(32'h10);
  localparam logic [AW-1:0] ADDR_DATA   = AW'(32'h14);
  localparam logic [AW-1:0] ADDR_THRESH = AW'(32'h18);

  typedef enum logic [1:0] {R_IDLE, R_LAT, R_RESP} rstate_e;

  rstate_e           r_rstate, w_rstate_nxt;
  logic              r_alive;
  logic [AW-1:0]     r_araddr;
  logic              r_rd_pop;
  logic [DATA_W-1:0] r_mem_q;
  logic [31:0]       r_rdata, w_rdata_nxt;

  logic [AW-1:0]     r_awaddr;
  logic [LVL_W-1:0]  r_wdata;
  logic              r_aw_have, r_w_have, r_bvalid;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [LVL_W-1:0]  r_level, r_thresh;
  logic              r_ovf, r_irq_en, r_irq;

  logic w_ar_hs, w_aw_hs, w_w_hs, w_b_hs;
  logic w_full, w_empty, w_thr, w_is_cr, w_flush, w_push, w_pop;

  assign w_full  = (r_level == LVL_W'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_thr   = (r_thresh != '0) && (r_level >= r_thresh);

  assign axi.awready = r_alive & ~r_aw_have & ~r_bvalid;
  assign axi.wready  = r_alive & ~r_w_have & ~r_bvalid;
  assign axi.bvalid  = r_bvalid;
  assign axi.bresp   = 2'b00;
  assign axi.rresp   = 2'b00;
  assign axi.rdata   = r_rdata;
  assign o_irq       = r_irq;

  assign w_ar_hs = axi.arvalid & axi.arready;
  assign w_aw_hs = axi.awvalid & axi.awready;
  assign w_w_hs  = axi.wvalid & axi.wready;
  assign w_b_hs  = r_bvalid & axi.bready;

  assign w_is_cr = (r_awaddr == ADDR_CR) | (r_awaddr == ADDR_CR_S) | (r_awaddr == ADDR_CR_C);
  assign w_flush = w_b_hs & w_is_cr & r_wdata[0];
  assign w_push  = i_wr_en & ~w_full & ~w_flush;
  assign w_pop   = w_ar_hs & (axi.araddr == ADDR_DATA) & ~w_empty;

  // r_alive keeps arready low for the first cycle after reset release.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rstate <= R_IDLE;
      r_alive  <= 1'b0;
    end else begin
      r_rstate <= w_rstate_nxt;
      r_alive  <= 1'b1;
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    axi.arready  = 1'b0;
    axi.rvalid   = 1'b0;
    unique case (r_rstate)
      R_IDLE: begin
        axi.arready = r_alive;
        if (axi.arvalid && r_alive) w_rstate_nxt = R_LAT;
      end
      R_LAT:  w_rstate_nxt = R_RESP;
      R_RESP: begin
        axi.rvalid = 1'b1;
        if (axi.rready) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_araddr <= '0;
      r_rd_pop <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (w_ar_hs) begin
        r_araddr <= axi.araddr;
        r_rd_pop <= w_pop;
      end
      if (r_rstate == R_LAT) r_rdata <= w_rdata_nxt;
    end
  end

  // Storage has no reset so it maps onto block RAM with a registered read port.
  always_ff @(posedge aclk) begin
    if (w_push) r_mem[r_wptr] <= i_data_in;
    if (w_ar_hs) r_mem_q <= r_mem[r_rptr];
  end

  always_comb begin
    w_rdata_nxt = '0;
    case (r_araddr)
      ADDR_SR:     w_rdata_nxt = {28'd0, w_thr, r_ovf, w_full, w_empty};
      ADDR_CR:     w_rdata_nxt = {30'd0, r_irq_en, 1'b0};
      ADDR_LEVEL:  w_rdata_nxt = 32'(r_level);
      ADDR_DATA:   if (r_rd_pop) w_rdata_nxt = 32'h8000_0000 | 32'(r_mem_q);
      ADDR_THRESH: w_rdata_nxt = 32'(r_thresh);
      default:     w_rdata_nxt = '0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_aw_have <= 1'b0;
      r_w_have  <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_awaddr  <= axi.awaddr;
        r_aw_have <= 1'b1;
      end
      if (w_w_hs) begin
        r_wdata  <= axi.wdata[LVL_W-1:0];
        r_w_have <= 1'b1;
      end
      if (w_b_hs) begin
        r_bvalid  <= 1'b0;
        r_aw_have <= 1'b0;
        r_w_have  <= 1'b0;
      end else if ((r_aw_have | w_aw_hs) & (r_w_have | w_w_hs)) begin
        r_bvalid <= 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_irq_en <= 1'b0;
      r_thresh <= '0;
      r_ovf    <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_b_hs) begin
        case (r_awaddr)
          ADDR_CR:     r_irq_en <= r_wdata[1];
          ADDR_CR_S:   if (r_wdata[1]) r_irq_en <= 1'b1;
          ADDR_CR_C:   if (r_wdata[1]) r_irq_en <= 1'b0;
          ADDR_THRESH: r_thresh <= r_wdata;
          default:     ;
        endcase
      end
      // A fresh drop wins over a same-cycle software clear.
      if (i_wr_en && w_full) begin
        r_ovf <= 1'b1;
      end else if (w_b_hs && (r_awaddr == ADDR_SR) && r_wdata[2]) begin
        r_ovf <= 1'b0;
      end
      r_irq <= r_irq_en & (w_thr | r_ovf);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_event_queue_axil.sv
// Directed bench for event_queue_axil with a queue-based reference model checked every cycle.
module tb_event_queue_axil;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AW     = 8;

  localparam logic [7:0] A_SR   = 8'h00;
  localparam logic [7:0] A_CR   = 8'h04;
  localparam logic [7:0] A_CRS  = 8'h08;
  localparam logic [7:0] A_CRC  = 8'h0C;
  localparam logic [7:0] A_LVL  = 8'h10;
  localparam logic [7:0] A_DATA = 8'h14;
  localparam logic [7:0] A_THR  = 8'h18;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       irq;

  int n_tests = 0;
  int n_fail  = 0;

  axi4_lite_if #(.ADDR_W(AW)) axi ();

  event_queue_axil #(
    .DATA_W         (DATA_W),
    .DEPTH          (DEPTH),
    .MMR_DEV_ADDR_W (AW)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .i_wr_en   (wr_en),
    .i_data_in (data_in),
    .o_irq     (irq),
    .axi       (axi)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no handshake within 50 cycles", name);
  endtask

  // Reference model: queue contents and software-visible state after each clock edge.
  logic [7:0]  mq[$];
  logic [31:0] exp_q[$];
  bit          m_ovf, m_irq_en, m_irq;
  logic [4:0]  m_thresh;
  bit          lat_pend, lat_pop;
  logic [7:0]  lat_addr, lat_popv;
  logic [7:0]  cur_waddr = 8'h00;
  logic [31:0] cur_wdata = 32'h0;
  bit          m_full, m_thr, m_nxt_irq, m_bhs, m_flush;

  function automatic logic [31:0] reg_val(input logic [7:0] a, input bit pop,
                                          input logic [7:0] pv);
    int lvl = mq.size();
    bit thr = (m_thresh != 0) && (lvl >= int'(m_thresh));
    case (a)
      A_SR:   return {28'd0, thr, m_ovf, lvl == DEPTH, lvl == 0};
      A_CR:   return {30'd0, m_irq_en, 1'b0};
      A_LVL:  return 32'(lvl);
      A_DATA: return pop ? (32'h8000_0000 | 32'(pv)) : 32'h0;
      A_THR:  return 32'(m_thresh);
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge aclk) begin
    if (!aresetn) begin
      mq.delete();
      exp_q.delete();
      m_ovf = 0; m_irq_en = 0; m_irq = 0; m_thresh = '0; lat_pend = 0;
    end else begin
      check("irq", 32'(irq), 32'(m_irq));
      if (axi.rvalid && axi.rready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rdata: got 0x%08h with no read outstanding", axi.rdata);
        end else begin
          check("rdata", axi.rdata, exp_q.pop_front());
        end
        check("rresp", 32'(axi.rresp), 32'h0);
      end
      if (axi.bvalid && axi.bready) check("bresp", 32'(axi.bresp), 32'h0);
      if (lat_pend) begin
        exp_q.push_back(reg_val(lat_addr, lat_pop, lat_popv));
        lat_pend = 0;
      end
      m_full    = (mq.size() == DEPTH);
      m_thr     = (m_thresh != 0) && (mq.size() >= int'(m_thresh));
      m_nxt_irq = m_irq_en && (m_thr || m_ovf);
      if (axi.arvalid && axi.arready) begin
        lat_pend = 1;
        lat_addr = axi.araddr;
        lat_pop  = (axi.araddr == A_DATA) && (mq.size() > 0);
        if (lat_pop) lat_popv = mq.pop_front();
      end
      m_bhs   = axi.bvalid && axi.bready;
      m_flush = m_bhs && (cur_waddr inside {A_CR, A_CRS, A_CRC}) && cur_wdata[0];
      if (m_flush) mq.delete();
      else if (wr_en && !m_full) mq.push_back(data_in);
      if (wr_en && m_full) m_ovf = 1;
      else if (m_bhs && cur_waddr == A_SR && cur_wdata[2]) m_ovf = 0;
      if (m_bhs) begin
        case (cur_waddr)
          A_CR:    m_irq_en = cur_wdata[1];
          A_CRS:   if (cur_wdata[1]) m_irq_en = 1;
          A_CRC:   if (cur_wdata[1]) m_irq_en = 0;
          A_THR:   m_thresh = cur_wdata[4:0];
          default: ;
        endcase
      end
      m_irq = m_nxt_irq;
    end
  end

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d);
    bit hs = 0;
    int k = 0;
    d = 32'h0;
    axi.araddr = a;
    axi.arvalid = 1'b1;
    while (!hs && k < 50) begin
      @(negedge aclk); hs = axi.arready; k++;
      @(posedge aclk); #1;
    end
    axi.arvalid = 1'b0;
    if (!hs) begin timeout("ar_handshake"); return; end
    hs = 0;
    k = 0;
    while (!hs && k < 50) begin
      @(negedge aclk); k++;
      if (axi.rvalid) begin hs = 1; d = axi.rdata; end
      @(posedge aclk); #1;
    end
    if (!hs) timeout("r_response");
    else check("rd_latency", 32'(k), 32'd2);
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input bit push_b,
                           input logic [7:0] code);
    bit hs = 0;
    int k = 0;
    cur_waddr = a; cur_wdata = d;
    axi.awaddr = a; axi.wdata = d;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    while (!hs && k < 50) begin
      @(negedge aclk); hs = axi.awready && axi.wready; k++;
      @(posedge aclk); #1;
    end
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    if (!hs) begin timeout("aw_w_handshake"); return; end
    if (push_b) begin wr_en = 1'b1; data_in = code; end
    hs = 0;
    k = 0;
    while (!hs && k < 50) begin
      @(negedge aclk); k++;
      if (axi.bvalid) hs = 1;
      @(posedge aclk); #1;
      wr_en = 1'b0;
    end
    if (!hs) timeout("b_response");
    else check("wr_latency", 32'(k), 32'd1);
  endtask

  task automatic push(input logic [7:0] c);
    wr_en = 1'b1; data_in = c;
    @(posedge aclk); #1;
    wr_en = 1'b0;
  endtask

  task automatic rd_expect(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(a, d);
    check(name, d, exp);
  endtask

  logic [31:0] d;
  logic [7:0]  got[$];
  int          order_err;

  initial begin
    axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b1; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b1;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_arready", 32'(axi.arready), 32'd0);
    check("rst_rvalid", 32'(axi.rvalid), 32'd0);
    check("rst_awready", 32'(axi.awready), 32'd0);
    check("rst_wready", 32'(axi.wready), 32'd0);
    check("rst_bvalid", 32'(axi.bvalid), 32'd0);
    check("rst_rdata", axi.rdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("arready_exit_cycle", 32'(axi.arready), 32'd0);
    @(negedge aclk);
    check("arready_rises", 32'(axi.arready), 32'd1);
    @(posedge aclk); #1;

    rd_expect("sr_reset", A_SR, 32'h1);
    rd_expect("level_reset", A_LVL, 32'h0);
    rd_expect("data_empty", A_DATA, 32'h0);
    rd_expect("level_after_empty_pop", A_LVL, 32'h0);
    rd_expect("undecoded", 8'h1C, 32'h0);

    push(8'h11); push(8'h22); push(8'h33);
    rd_expect("level_3", A_LVL, 32'h3);
    rd_expect("data_11", A_DATA, 32'h8000_0011);
    rd_expect("data_22", A_DATA, 32'h8000_0022);
    rd_expect("data_33", A_DATA, 32'h8000_0033);
    rd_expect("sr_empty", A_SR, 32'h1);

    for (int i = 0; i < DEPTH + 2; i++) push(8'h40 + 8'(i));
    rd_expect("level_full", A_LVL, 32'd16);
    rd_expect("sr_full_ovf", A_SR, 32'h6);
    for (int i = 0; i < DEPTH; i++) rd_expect("data_full_order", A_DATA, 32'h8000_0040 + i);
    rd_expect("sr_empty_ovf", A_SR, 32'h5);
    axi_write(A_SR, 32'h4, 1'b0, 8'h00);
    rd_expect("sr_ovf_cleared", A_SR, 32'h1);

    axi_write(A_THR, 32'h4, 1'b0, 8'h00);
    axi_write(A_CRS, 32'h2, 1'b0, 8'h00);
    rd_expect("thresh_rb", A_THR, 32'h4);
    rd_expect("cr_rb", A_CR, 32'h2);
    rd_expect("crs_reads_zero", A_CRS, 32'h0);
    push(8'h50); push(8'h51); push(8'h52); push(8'h53);
    @(negedge aclk);
    check("irq_push_plus1", 32'(irq), 32'd0);
    @(negedge aclk);
    check("irq_push_plus2", 32'(irq), 32'd1);
    @(posedge aclk); #1;
    rd_expect("sr_thr", A_SR, 32'h8);
    rd_expect("data_50", A_DATA, 32'h8000_0050);
    check("irq_after_pop", 32'(irq), 32'd0);

    push(8'h54); push(8'h55);
    rd_expect("level_5", A_LVL, 32'h5);
    axi_write(A_CRS, 32'h1, 1'b1, 8'hEE);
    rd_expect("level_flushed", A_LVL, 32'h0);
    rd_expect("sr_flushed", A_SR, 32'h1);
    rd_expect("cr_after_flush", A_CR, 32'h2);

    axi_write(A_THR, 32'h0, 1'b0, 8'h00);
    axi_write(A_CRC, 32'h2, 1'b0, 8'h00);
    for (int i = 1; i <= DEPTH; i++) push(8'(i));
    fork
      begin
        for (int i = DEPTH + 1; i <= 40; i++) begin
          wr_en = 1'b1; data_in = 8'(i);
          @(posedge aclk); #1;
        end
        wr_en = 1'b0;
      end
      begin
        for (int j = 0; j < 30; j++) begin
          axi_read(A_DATA, d);
          if (d[31]) got.push_back(d[7:0]);
        end
      end
    join
    for (int j = 0; j < 20; j++) begin
      axi_read(A_DATA, d);
      if (!d[31]) break;
      got.push_back(d[7:0]);
    end
    check("stream_first", (got.size() > 0) ? 32'(got[0]) : 32'hFFFF_FFFF, 32'd1);
    order_err = 0;
    for (int j = 1; j < got.size(); j++) if (got[j] <= got[j-1]) order_err++;
    check("stream_order", 32'(order_err), 32'd0);
    axi_read(A_SR, d);
    check("stream_ovf_flag", d & 32'h4, 32'h4);
    axi_write(A_SR, 32'h4, 1'b0, 8'h00);

    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < 8; j++) push(8'h90 + 8'(8 * r + j));
      for (int j = 0; j < 8; j++)
        rd_expect("wrap_order", A_DATA, 32'h8000_0090 + 32'(8 * r + j));
    end
    rd_expect("sr_after_wrap", A_SR, 32'h1);

    push(8'hA1); push(8'hA2); push(8'hA3);
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    rd_expect("level_after_reset", A_LVL, 32'h0);
    rd_expect("sr_after_reset", A_SR, 32'h1);
    rd_expect("cr_after_reset", A_CR, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
